pc_seq: RTL and testbench

- Parametrised successor to the core's program counter: next-PC logic for the single-cycle CPU.
- Supports selectable program entry points, signed relative branches, absolute jumps, and call/return through an internal return-address stack.
- Adds stall hold, HALT detection and a sticky fault flag.
- Sits between decode (op, flags, immediates) and instruction ROM address.

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_seq_ret_stack.sv | 44 ++++
 rtl/pc_seq.sv | 120 ++++++++++++
 tb/tb_pc_seq.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Definitions shared by the next-PC sequencer: opcode encodings and program entry table.
package pc_seq_pkg;

  localparam logic [4:0] NOP  = 5'h00;
  localparam logic [4:0] BA   = 5'h08;
  localparam logic [4:0] BL   = 5'h09;
  localparam logic [4:0] BG   = 5'h0A;
  localparam logic [4:0] BE   = 5'h0B;
  localparam logic [4:0] JMP  = 5'h0C;
  localparam logic [4:0] CALL = 5'h0D;
  localparam logic [4:0] RET  = 5'h0E;
  localparam logic [4:0] HALT = 5'h0F;

  localparam int ENTRY_NUM = 3;
  localparam int ENTRY_PC [ENTRY_NUM] = '{0, 25, 44};

endpackage

// File: rtl/pc_seq_ret_stack.sv
// LIFO of return addresses; dout is the current top, valid only when !empty.
module ret_stack #(
  parameter int PC_W        = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0] mem [STACK_DEPTH];
  logic [SPW-1:0]  sp;
  logic [SPW-1:0]  sp_m1;
  logic [AW-1:0]   wr_idx;
  logic [AW-1:0]   rd_idx;

  assign sp_m1  = sp - SPW'(1);
  assign wr_idx = AW'(sp);
  assign rd_idx = AW'(sp_m1);
  assign empty  = (sp == '0);
  assign full   = (sp == SPW'(STACK_DEPTH));
  assign dout   = mem[rd_idx];

  // Only the pointer is reset; entries above it are never read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      sp          <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Next-PC sequencer: entry select, relative branches, jumps, call/return, stall, halt and sticky fault.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int OFF_W       = 15,
  parameter int NUM_PROG    = 3,
  parameter int STACK_DEPTH = 4,
  localparam int SEL_W      = (NUM_PROG > 1) ? $clog2(NUM_PROG) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] prog_sel,
  input  logic [4:0]       op,
  input  logic             z,
  input  logic             lt,
  input  logic [OFF_W-1:0] bamt,
  input  logic [PC_W-1:0]  jaddr,
  input  logic             stall,
  output logic [PC_W-1:0]  PC,
  output logic             halted,
  output logic             fault
);

  localparam int EW = (OFF_W > PC_W) ? OFF_W : PC_W;

  logic [PC_W-1:0] pc_q, pc_nxt, pc_inc, br_tgt, entry_pc, stk_dout;
  logic [EW-1:0]   off_ext;
  logic            halted_nxt, fault_nxt, sel_ok, taken;
  logic            push, pop, stk_full, stk_empty;

  assign PC      = pc_q;
  assign pc_inc  = pc_q + PC_W'(1);
  assign off_ext = EW'($signed(bamt));
  assign br_tgt  = pc_q + off_ext[PC_W-1:0];

  // Out-of-range selections fall back to the first entry and flag a fault.
  always_comb begin
    entry_pc = PC_W'(ENTRY_PC[0]);
    sel_ok   = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (i < NUM_PROG && prog_sel == SEL_W'(i)) begin
        entry_pc = PC_W'(ENTRY_PC[i]);
        sel_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    taken = 1'b0;
    case (op)
      BA:      taken = 1'b1;
      BL:      taken = lt;
      BG:      taken = !lt;
      BE:      taken = z;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_nxt     = pc_q;
    halted_nxt = halted;
    fault_nxt  = fault;
    push       = 1'b0;
    pop        = 1'b0;
    if (!halted && !stall) begin
      case (op)
        BA, BL, BG, BE: pc_nxt = taken ? br_tgt : pc_inc;
        JMP:            pc_nxt = jaddr;
        CALL: begin
          if (stk_full) begin
            fault_nxt  = 1'b1;
            halted_nxt = 1'b1;
          end else begin
            push   = 1'b1;
            pc_nxt = jaddr;
          end
        end
        RET: begin
          if (stk_empty) begin
            fault_nxt  = 1'b1;
            halted_nxt = 1'b1;
          end else begin
            pop    = 1'b1;
            pc_nxt = stk_dout;
          end
        end
        HALT:    halted_nxt = 1'b1;
        default: pc_nxt = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q   <= entry_pc;
      halted <= 1'b0;
      fault  <= !sel_ok;
    end else begin
      pc_q   <= pc_nxt;
      halted <= halted_nxt;
      fault  <= fault_nxt;
    end
  end

  ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq with hand-computed expected PC/flag values.
module tb_pc_seq;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  prog_sel;
  logic [4:0]  op;
  logic        z, lt, stall;
  logic [14:0] bamt;
  logic [7:0]  jaddr;
  logic [7:0]  PC;
  logic        halted, fault;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_seq dut (
    .clk(clk), .reset(reset), .prog_sel(prog_sel), .op(op), .z(z), .lt(lt),
    .bamt(bamt), .jaddr(jaddr), .stall(stall), .PC(PC), .halted(halted), .fault(fault)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [4:0] o, input logic [14:0] b, input logic [7:0] j,
                       input logic zz, input logic ll);
    op = o; bamt = b; jaddr = j; z = zz; lt = ll;
    step(1);
  endtask

  task automatic do_reset(input logic [1:0] sel, input int cycles);
    reset = 1'b0; prog_sel = sel; op = NOP;
    step(cycles);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; prog_sel = 2'd0; op = NOP; z = 0; lt = 0; stall = 0;
    bamt = '0; jaddr = '0;

    // entry points
    do_reset(2'd1, 2);
    chk("entry1_pc", PC, 25);
    chk("entry1_halted", halted, 0);
    chk("entry1_fault", fault, 0);
    do_reset(2'd2, 2);
    chk("entry2_pc", PC, 44);
    do_reset(2'd3, 2);
    chk("entry3_pc", PC, 0);
    chk("entry3_fault", fault, 1);
    do_reset(2'd0, 1);
    chk("entry0_fault", fault, 0);

    // sequential with wrap
    do_op(JMP, '0, 8'd254, 0, 0);
    chk("jmp254", PC, 254);
    do_op(NOP, '0, 0, 0, 0); chk("seq255", PC, 255);
    do_op(NOP, '0, 0, 0, 0); chk("seq0", PC, 0);
    do_op(NOP, '0, 0, 0, 0); chk("seq1", PC, 1);

    // branches
    do_op(JMP, '0, 8'd10, 0, 0);          chk("jmp10", PC, 10);
    do_op(BL, 15'h7FFD, 0, 0, 1);         chk("bl_taken", PC, 7);
    do_op(BL, 15'h7FFD, 0, 0, 0);         chk("bl_not", PC, 8);
    do_op(BE, 15'd5, 0, 1, 0);            chk("be_taken", PC, 13);
    do_op(BA, 15'h7FF2, 0, 0, 0);         chk("ba_wrap", PC, 255);
    do_op(BG, 15'd2, 0, 0, 0);            chk("bg_taken", PC, 1);
    do_op(BG, 15'd2, 0, 0, 1);            chk("bg_not", PC, 2);
    do_op(BE, 15'd9, 0, 0, 1);            chk("be_not", PC, 3);

    // call / return
    do_op(JMP, '0, 8'd30, 0, 0);          chk("jmp30", PC, 30);
    do_op(CALL, '0, 8'd100, 0, 0);        chk("call100", PC, 100);
    do_op(CALL, '0, 8'd120, 0, 0);        chk("call120", PC, 120);
    do_op(RET, '0, 0, 0, 0);              chk("ret101", PC, 101);
    do_op(RET, '0, 0, 0, 0);              chk("ret31", PC, 31);
    chk("stack_empty", dut.u_stack.empty, 1);
    chk("callret_halted", halted, 0);

    // stall during CALL
    stall = 1'b1;
    do_op(CALL, '0, 8'd60, 0, 0);
    step(1);
    chk("stall_pc", PC, 31);
    chk("stall_empty", dut.u_stack.empty, 1);
    stall = 1'b0;
    do_op(CALL, '0, 8'd60, 0, 0);         chk("call_after_stall", PC, 60);
    chk("stack_nonempty", dut.u_stack.empty, 0);
    do_op(RET, '0, 0, 0, 0);              chk("ret32", PC, 32);

    // overflow
    do_op(CALL, '0, 8'd200, 0, 0);
    do_op(CALL, '0, 8'd201, 0, 0);
    do_op(CALL, '0, 8'd202, 0, 0);
    do_op(CALL, '0, 8'd203, 0, 0);        chk("call4_pc", PC, 203);
    chk("stack_full", dut.u_stack.full, 1);
    do_op(CALL, '0, 8'd210, 0, 0);
    chk("ovf_pc", PC, 203);
    chk("ovf_fault", fault, 1);
    chk("ovf_halted", halted, 1);
    do_op(RET, '0, 0, 0, 0);
    do_op(JMP, '0, 8'd5, 0, 0);
    chk("ovf_sticky_pc", PC, 203);
    chk("ovf_sticky_fault", fault, 1);

    // reset discards stack; RET on empty stack
    do_reset(2'd0, 1);
    chk("rst_fault_clr", fault, 0);
    chk("rst_halted_clr", halted, 0);
    do_op(RET, '0, 0, 0, 0);
    chk("unf_pc", PC, 0);
    chk("unf_fault", fault, 1);
    chk("unf_halted", halted, 1);
    do_op(NOP, '0, 0, 0, 0);
    chk("unf_sticky", fault, 1);

    // HALT freeze
    do_reset(2'd0, 1);
    do_op(JMP, '0, 8'd40, 0, 0);
    do_op(HALT, '0, 0, 0, 0);
    chk("halt_fault", fault, 0);
    for (int i = 0; i < 10; i++) begin
      do_op(5'($urandom_range(0, 31)), 15'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      chk("halt_pc", PC, 40);
      chk("halt_flag", halted, 1);
    end
    do_reset(2'd2, 1);
    chk("halt_rst_pc", PC, 44);
    chk("halt_rst_flag", halted, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
